// File: rtl/sfp_rx_deframer_pkg.sv
// rtl/sfp_rx_deframer_pkg.sv - shared SFP framing constants and FSM encoding
package sfp_rx_deframer_pkg;

    localparam int          BEAT_W    = 32;
    localparam logic [15:0] SYNC_WORD = 16'h00FF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DISCARD = 2'd2
    } sfp_state_e;

    function automatic logic sync_ok(input logic [BEAT_W-1:0] beat);
        return beat[15:0] == SYNC_WORD;
    endfunction

endpackage

// File: rtl/sfp_rx_timer.sv
// rtl/sfp_rx_timer.sv - reloadable down-counter with expiry flag
module sfp_rx_timer #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_en && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = (count_q == '0);

endmodule

// File: rtl/sfp_rx_deframer.sv
// rtl/sfp_rx_deframer.sv - assembles 32-bit SFP beats into a checked wide frame
module sfp_rx_deframer
    import sfp_rx_deframer_pkg::*;
#(
    parameter int C_DATA_STREAM_BIT = 1344,
    parameter int C_GAP_TIMEOUT     = 255,
    parameter int C_LINK_TIMEOUT    = 100000
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [31:0]                  s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [C_DATA_STREAM_BIT-1:0] o_stream_data,
    output logic                         o_data_valid,
    output logic                         o_frame_err,
    output logic                         o_link_up,
    output logic [31:0]                  o_frame_cnt,
    output logic [15:0]                  o_err_cnt
);

    localparam int N_BEATS = C_DATA_STREAM_BIT / BEAT_W;
    localparam int CNT_W   = (N_BEATS < 2) ? 1 : $clog2(N_BEATS);
    localparam int GAP_W   = (C_GAP_TIMEOUT < 1) ? 1 : $clog2(C_GAP_TIMEOUT + 1);
    localparam int LINK_W  = (C_LINK_TIMEOUT < 1) ? 1 : $clog2(C_LINK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BEATS - 1);

    sfp_state_e                   state_q, state_d;
    logic [CNT_W-1:0]             beat_cnt_q, beat_cnt_d;
    logic [C_DATA_STREAM_BIT-1:0] shadow_q, shadow_d;
    logic [C_DATA_STREAM_BIT-1:0] stream_q, stream_d;
    logic                         data_valid_q, data_valid_d;
    logic                         frame_err_q, frame_err_d;
    logic                         link_up_q, link_up_d;
    logic [31:0]                  frame_cnt_q, frame_cnt_d;
    logic [15:0]                  err_cnt_q, err_cnt_d;

    logic                         beat_acc;
    logic                         accept_beat;
    logic                         good_frame;
    logic                         reject;
    logic [CNT_W-1:0]             beat_idx;
    logic                         is_last_idx;
    logic [C_DATA_STREAM_BIT-1:0] merged;
    logic                         gap_expired;
    logic                         link_expired;

    assign s_axis_tready = ~i_rst;
    assign beat_acc      = s_axis_tvalid & s_axis_tready;
    assign beat_idx      = (state_q == ST_COLLECT) ? beat_cnt_q : '0;
    assign is_last_idx   = (beat_idx == LAST_IDX);

    // The shadow buffer with the current beat dropped into its slot; the
    // visible frame only ever takes this whole vector on a good last beat.
    always_comb begin
        merged = shadow_q;
        merged[int'(beat_idx)*BEAT_W +: BEAT_W] = s_axis_tdata;
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        shadow_d    = shadow_q;
        stream_d    = stream_q;
        accept_beat = 1'b0;
        good_frame  = 1'b0;
        reject      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (beat_acc) begin
                    if (!sync_ok(s_axis_tdata)) begin
                        reject  = 1'b1;
                        state_d = s_axis_tlast ? ST_IDLE : ST_DISCARD;
                    end else begin
                        accept_beat = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (beat_acc) begin
                    accept_beat = 1'b1;
                end else if (gap_expired) begin
                    reject  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (beat_acc && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept_beat) begin
            if (s_axis_tlast) begin
                state_d = ST_IDLE;
                if (is_last_idx) begin
                    good_frame = 1'b1;
                    stream_d   = merged;
                end else begin
                    reject = 1'b1;
                end
            end else if (is_last_idx) begin
                reject  = 1'b1;
                state_d = ST_DISCARD;
            end else begin
                shadow_d   = merged;
                beat_cnt_d = beat_idx + CNT_W'(1);
                state_d    = ST_COLLECT;
            end
        end
    end

    always_comb begin
        data_valid_d = good_frame;
        frame_err_d  = reject;
        frame_cnt_d  = good_frame ? frame_cnt_q + 32'd1 : frame_cnt_q;
        err_cnt_d    = (reject && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
        link_up_d    = link_up_q;
        if (good_frame) begin
            link_up_d = 1'b1;
        end else if (link_expired) begin
            link_up_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            shadow_q     <= '0;
            stream_q     <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            link_up_q    <= 1'b0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            shadow_q     <= shadow_d;
            stream_q     <= stream_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            link_up_q    <= link_up_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Gap timer restarts on every accepted beat and only runs mid-frame.
    sfp_rx_timer #(
        .CNT_W (GAP_W)
    ) u_gap_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (beat_acc),
        .i_load_val (GAP_W'(C_GAP_TIMEOUT)),
        .i_en       (state_q == ST_COLLECT),
        .o_expired  (gap_expired)
    );

    sfp_rx_timer #(
        .CNT_W (LINK_W)
    ) u_link_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (good_frame),
        .i_load_val (LINK_W'(C_LINK_TIMEOUT)),
        .i_en       (1'b1),
        .o_expired  (link_expired)
    );

    assign o_stream_data = stream_q;
    assign o_data_valid  = data_valid_q;
    assign o_frame_err   = frame_err_q;
    assign o_link_up     = link_up_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_sfp_rx_deframer.sv
// tb/tb_sfp_rx_deframer.sv - scoreboard bench for sfp_rx_deframer
module tb_sfp_rx_deframer;

    logic         clk = 1'b0;
    logic         i_rst;
    logic [31:0]  s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [127:0] o_stream_data;
    logic         o_data_valid;
    logic         o_frame_err;
    logic         o_link_up;
    logic [31:0]  o_frame_cnt;
    logic [15:0]  o_err_cnt;

    always #5 clk = ~clk;

    sfp_rx_deframer #(
        .C_DATA_STREAM_BIT (128),
        .C_GAP_TIMEOUT     (4),
        .C_LINK_TIMEOUT    (50)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .o_stream_data (o_stream_data),
        .o_data_valid  (o_data_valid),
        .o_frame_err   (o_frame_err),
        .o_link_up     (o_link_up),
        .o_frame_cnt   (o_frame_cnt),
        .o_err_cnt     (o_err_cnt)
    );

    typedef struct {
        logic [127:0] data;
        logic [31:0]  cnt;
    } exp_good_t;

    typedef struct {
        logic [127:0] hold;
        logic [15:0]  cnt;
    } exp_err_t;

    exp_good_t    good_q[$];
    exp_err_t     err_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [31:0]  exp_frames = 0;
    logic [15:0]  exp_errs   = 0;
    logic [127:0] last_good  = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_good(input logic [127:0] data);
        exp_frames = exp_frames + 32'd1;
        last_good  = data;
        good_q.push_back('{data: data, cnt: exp_frames});
    endtask

    task automatic push_err();
        exp_errs = exp_errs + 16'd1;
        err_q.push_back('{hold: last_good, cnt: exp_errs});
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_data_valid) begin
                check("dv_excl_err", {127'd0, o_frame_err}, 128'd0);
                if (good_q.size() == 0) begin
                    check("unexpected_dv", {127'd0, o_data_valid}, 128'd0);
                end else begin
                    exp_good_t g;
                    g = good_q.pop_front();
                    check("frame_data", o_stream_data, g.data);
                    check("frame_cnt", {96'd0, o_frame_cnt}, {96'd0, g.cnt});
                end
            end
            if (o_frame_err) begin
                if (err_q.size() == 0) begin
                    check("unexpected_err", {127'd0, o_frame_err}, 128'd0);
                end else begin
                    exp_err_t e;
                    e = err_q.pop_front();
                    check("err_hold_data", o_stream_data, e.hold);
                    check("err_cnt", {112'd0, o_err_cnt}, {112'd0, e.cnt});
                end
            end
        end
    end

    initial begin
        i_rst         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        idle(3);
        check("rst_tready", {127'd0, s_axis_tready}, 128'd0);
        check("rst_stream", o_stream_data, 128'd0);
        check("rst_dv", {127'd0, o_data_valid}, 128'd0);
        check("rst_err", {127'd0, o_frame_err}, 128'd0);
        check("rst_link", {127'd0, o_link_up}, 128'd0);
        check("rst_fcnt", {96'd0, o_frame_cnt}, 128'd0);
        check("rst_ecnt", {112'd0, o_err_cnt}, 128'd0);
        i_rst = 1'b0;
        #1;
        check("tready_run", {127'd0, s_axis_tready}, 128'd1);

        push_good(128'h0000000C_0000000B_0000000A_123400FF);
        beat(32'h123400FF, 1'b0); beat(32'hA, 1'b0); beat(32'hB, 1'b0); beat(32'hC, 1'b1);
        idle(2);
        check("link_after_a", {127'd0, o_link_up}, 128'd1);
        check("fcnt_after_a", {96'd0, o_frame_cnt}, 128'd1);

        push_err();
        beat(32'h000000FE, 1'b0); beat(32'h1, 1'b0); beat(32'h2, 1'b0); beat(32'h3, 1'b1);
        idle(2);
        check("ecnt_bad_sync", {112'd0, o_err_cnt}, 128'd1);
        check("stream_kept", o_stream_data, 128'h0000000C_0000000B_0000000A_123400FF);

        push_err();
        beat(32'h555500FF, 1'b0); beat(32'h1, 1'b1);
        push_good(128'h00000033_00000022_00000011_BEEF00FF);
        beat(32'hBEEF00FF, 1'b0); beat(32'h11, 1'b0); beat(32'h22, 1'b0); beat(32'h33, 1'b1);

        push_err();
        beat(32'h000100FF, 1'b0); beat(32'h1, 1'b0); beat(32'h2, 1'b0); beat(32'h3, 1'b0);
        beat(32'h4, 1'b1);
        push_good(128'h00000066_00000055_00000044_C0DE00FF);
        beat(32'hC0DE00FF, 1'b0); beat(32'h44, 1'b0); beat(32'h55, 1'b0); beat(32'h66, 1'b1);

        push_err();
        beat(32'h777700FF, 1'b0); beat(32'h1, 1'b0);
        idle(5);
        push_good(128'h00000099_00000088_00000077_D00D00FF);
        beat(32'hD00D00FF, 1'b0); beat(32'h77, 1'b0);
        idle(4);
        beat(32'h88, 1'b0); beat(32'h99, 1'b1);
        idle(3);
        check("ecnt_before_rst", {112'd0, o_err_cnt}, 128'd4);

        beat(32'h888800FF, 1'b0); beat(32'h1, 1'b0);
        i_rst = 1'b1;
        idle(2);
        check("midrst_fcnt", {96'd0, o_frame_cnt}, 128'd0);
        check("midrst_ecnt", {112'd0, o_err_cnt}, 128'd0);
        check("midrst_link", {127'd0, o_link_up}, 128'd0);
        check("midrst_stream", o_stream_data, 128'd0);
        exp_frames = 0;
        exp_errs   = 0;
        last_good  = '0;
        i_rst = 1'b0;
        #1;

        push_good(128'h000000CC_000000BB_000000AA_E00E00FF);
        beat(32'hE00E00FF, 1'b0); beat(32'hAA, 1'b0); beat(32'hBB, 1'b0); beat(32'hCC, 1'b1);
        idle(50);
        check("link_held_50", {127'd0, o_link_up}, 128'd1);
        idle(1);
        check("link_down_51", {127'd0, o_link_up}, 128'd0);

        idle(3);
        check("good_q_empty", 128'(good_q.size()), 128'd0);
        check("err_q_empty", 128'(err_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
